// File: rtl/sim_halt_monitor_pkg.sv
// sim_monitor_pkg
// Shared definitions for the end-of-run monitor: the controller state
// encoding, the default "test passed" trap code, the default counter width
// and the slot numbers of the three performance counters.
package sim_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Trap immediate that marks a passing test.
  localparam logic [25:0] END_CODE_DEFAULT = 26'h300;

  // Default width of a saturating counter.
  localparam int SAT_W_DEFAULT = 32;

  // Slots in the monitor's counter bank.
  localparam int CNT_CYCLE  = 0;
  localparam int CNT_RETIRE = 1;
  localparam int CNT_STALL  = 2;
  localparam int CNT_NUM    = 3;

endpackage

// File: rtl/sim_halt_monitor_sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, clears the count
//   clr   - synchronous clear (wins over inc)
//   inc   - add one this cycle unless already at maximum
//   q     - current count
module sat_counter
  import sim_monitor_pkg::*;
#(
  parameter int W = SAT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor
// End-of-run monitor for the pipelined processor. Once enabled it watches
// the MEM-stage trap, retirements and stalls, runs a watchdog, drains the
// pipeline for DRAIN_CYCLES after a trap and then reports pass / fail /
// timeout together with performance counters. All outputs are registered.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   enable             - start a run (looked at only in IDLE)
//   clear              - leave DONE for IDLE (looked at only in DONE)
//   trap_mem/trap_code - trap valid in MEM and its immediate
//   retire_valid       - one instruction retired this cycle
//   stall              - hazard stall this cycle
//   done/halt_req      - run finished (sticky), pipeline freeze request
//   pass/timed_out     - finished on END_CODE / finished by the watchdog
//   trap_code_q        - trap code captured at the finishing trap
//   cycle_count, retire_count, stall_count - saturating counters
module sim_halt_monitor
  import sim_monitor_pkg::*;
#(
  parameter int                CNT_W        = 32,
  parameter int                TIMEOUT      = 5000,
  parameter int                DRAIN_CYCLES = 10,
  parameter int                TRAP_W       = 26,
  parameter logic [TRAP_W-1:0] END_CODE     = TRAP_W'(END_CODE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              trap_mem,
  input  logic [TRAP_W-1:0] trap_code,
  input  logic              retire_valid,
  input  logic              stall,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic              halt_req,
  output logic [TRAP_W-1:0] trap_code_q,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  stall_count
);

  // A zero-cycle drain still needs a legal (unused) counter width.
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  // The cycle counter saturates, so a limit it can never reach must never
  // fire (a truncated compare would otherwise alias onto a small value).
  localparam bit               WD_REACHABLE = ($clog2(TIMEOUT) <= CNT_W);
  localparam logic [CNT_W-1:0] WD_LAST      = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timed_out_q, timed_out_d;
  logic [TRAP_W-1:0]   code_q, code_d;

  logic                cnt_clr;
  logic [CNT_NUM-1:0]  cnt_inc;
  logic [CNT_W-1:0]    cnt_val [CNT_NUM];
  logic                wd_hit;

  assign wd_hit = WD_REACHABLE && (cnt_val[CNT_CYCLE] == WD_LAST);

  // Counter bank: cleared on the IDLE->RUN edge, frozen outside RUN/DRAIN.
  assign cnt_clr = (state_q == ST_IDLE) && enable;
  assign cnt_inc[CNT_CYCLE]  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign cnt_inc[CNT_RETIRE] = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && retire_valid;
  assign cnt_inc[CNT_STALL]  = (state_q == ST_RUN) && stall;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc[gi]),
        .q     (cnt_val[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    code_d      = code_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_RUN;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          code_d      = '0;
        end
      end
      ST_RUN: begin
        // Trap is checked first so it beats a simultaneous watchdog expiry.
        if (trap_mem) begin
          code_d  = trap_code;
          pass_d  = (trap_code == END_CODE);
          drain_d = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (wd_hit) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d     = ST_IDLE;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          code_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      code_q      <= code_d;
    end
  end

  assign done         = done_q;
  assign halt_req     = done_q;
  assign pass         = pass_q;
  assign timed_out    = timed_out_q;
  assign trap_code_q  = code_q;
  assign cycle_count  = cnt_val[CNT_CYCLE];
  assign retire_count = cnt_val[CNT_RETIRE];
  assign stall_count  = cnt_val[CNT_STALL];

endmodule
